// File: rtl/bf_pkg.sv
// Shared types for the brainfuck core: bracket-controller opcodes and
// loop-controller state encoding.
package bf_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_OPEN  = 2'd1,
        OP_CLOSE = 2'd2,
        OP_OTHER = 2'd3
    } bf_op_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SKIP  = 2'd1,
        ERROR = 2'd2
    } bf_state_e;

endpackage

// File: rtl/bf_loop_ctrl.sv
// Bracket loop controller: pushes taken '[' PCs onto an external stack,
// branches back on ']' and performs the nested forward-skip on a zero cell.
module bf_loop_ctrl
    import bf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_pc,
    input  logic             cell_zero,
    output logic             skip,
    output logic             jump_valid,
    output logic [WIDTH-1:0] jump_pc,
    output logic [DEPTH:0]   sp,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic [DEPTH-1:0] stk_ra,
    input  logic [WIDTH-1:0] stk_rd,
    output logic             stk_we,
    output logic [DEPTH-1:0] stk_wa,
    output logic [WIDTH-1:0] stk_wd
);

    localparam logic [DEPTH:0]   SP_FULL   = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0]   SP_ZERO   = {(DEPTH+1){1'b0}};
    localparam logic [WIDTH-1:0] NEST_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] NEST_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    bf_state_e        state_q, state_d;
    logic [DEPTH:0]   sp_q, sp_d;
    logic [WIDTH-1:0] nest_q, nest_d;
    logic             jump_valid_q, jump_valid_d;
    logic [WIDTH-1:0] jump_pc_q, jump_pc_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;

    logic accept_s;
    logic is_open_s;
    logic is_close_s;
    logic full_s;
    logic empty_s;
    logic ready_s;

    assign is_open_s  = (cmd_op == OP_OPEN);
    assign is_close_s = (cmd_op == OP_CLOSE);
    assign full_s     = (sp_q == SP_FULL);
    assign empty_s    = (sp_q == SP_ZERO);
    assign ready_s    = (state_q != ERROR);
    assign accept_s   = cmd_valid & ready_s;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            sp_q         <= SP_ZERO;
            nest_q       <= {WIDTH{1'b0}};
            jump_valid_q <= 1'b0;
            jump_pc_q    <= {WIDTH{1'b0}};
            err_ovf_q    <= 1'b0;
            err_unf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            nest_q       <= nest_d;
            jump_valid_q <= jump_valid_d;
            jump_pc_q    <= jump_pc_d;
            err_ovf_q    <= err_ovf_d;
            err_unf_q    <= err_unf_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (accept_s && is_open_s) begin
                    if (cell_zero) begin
                        state_d = SKIP;
                    end else if (full_s) begin
                        state_d = ERROR;
                    end else begin
                        state_d = RUN;
                    end
                end else if (accept_s && is_close_s && empty_s) begin
                    state_d = ERROR;
                end else begin
                    state_d = RUN;
                end
            end
            SKIP: begin
                if (accept_s && is_open_s && (nest_q == NEST_MAX)) begin
                    state_d = ERROR;
                end else if (accept_s && is_close_s && (nest_q == NEST_ONE)) begin
                    state_d = RUN;
                end else begin
                    state_d = SKIP;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    // Stack pointer, skip nesting depth, jump target and sticky errors
    always_comb begin
        sp_d         = sp_q;
        nest_d       = nest_q;
        jump_valid_d = 1'b0;
        jump_pc_d    = jump_pc_q;
        err_ovf_d    = err_ovf_q;
        err_unf_d    = err_unf_q;
        case (state_q)
            RUN: begin
                if (accept_s && is_open_s) begin
                    if (cell_zero) begin
                        nest_d = NEST_ONE;
                    end else if (full_s) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        sp_d = sp_q + {{DEPTH{1'b0}}, 1'b1};
                    end
                end else if (accept_s && is_close_s) begin
                    if (empty_s) begin
                        err_unf_d = 1'b1;
                    end else if (!cell_zero) begin
                        // Branch to the instruction just after the saved '['
                        jump_valid_d = 1'b1;
                        jump_pc_d    = stk_rd + NEST_ONE;
                    end else begin
                        sp_d = sp_q - {{DEPTH{1'b0}}, 1'b1};
                    end
                end else begin
                    sp_d = sp_q;
                end
            end
            SKIP: begin
                if (accept_s && is_open_s) begin
                    if (nest_q == NEST_MAX) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        nest_d = nest_q + NEST_ONE;
                    end
                end else if (accept_s && is_close_s) begin
                    nest_d = nest_q - NEST_ONE;
                end else begin
                    nest_d = nest_q;
                end
            end
            ERROR:   jump_valid_d = 1'b0;
            default: jump_valid_d = 1'b0;
        endcase
    end

    // Outputs and stack port drive
    always_comb begin
        cmd_ready     = ready_s;
        skip          = (state_q == SKIP);
        jump_valid    = jump_valid_q;
        jump_pc       = jump_pc_q;
        sp            = sp_q;
        err_overflow  = err_ovf_q;
        err_underflow = err_unf_q;
        stk_ra        = sp_q[DEPTH-1:0] - {{(DEPTH-1){1'b0}}, 1'b1};
        stk_wa        = sp_q[DEPTH-1:0];
        stk_wd        = cmd_pc;
        stk_we        = accept_s & (state_q == RUN) & is_open_s & ~cell_zero & ~full_s;
    end

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Scoreboarded bench for bf_loop_ctrl: a queue-based loop model predicts
// stack writes, jumps and status; a negedge monitor compares them.
module tb_bf_loop_ctrl;

    localparam int DEPTH = 2;
    localparam int WIDTH = 16;
    localparam int CAP   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [WIDTH-1:0] cmd_pc = 16'd0;
    logic             cell_zero = 1'b0;
    logic             skip;
    logic             jump_valid;
    logic [WIDTH-1:0] jump_pc;
    logic [DEPTH:0]   sp;
    logic             err_overflow;
    logic             err_underflow;
    logic [DEPTH-1:0] stk_ra;
    logic [WIDTH-1:0] stk_rd;
    logic             stk_we;
    logic [DEPTH-1:0] stk_wa;
    logic [WIDTH-1:0] stk_wd;

    bf_loop_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_pc(cmd_pc), .cell_zero(cell_zero), .skip(skip),
        .jump_valid(jump_valid), .jump_pc(jump_pc), .sp(sp),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .stk_ra(stk_ra), .stk_rd(stk_rd), .stk_we(stk_we), .stk_wa(stk_wa),
        .stk_wd(stk_wd)
    );

    always #5 clk = ~clk;

    // Stack storage the controller drives: async read, sync write
    logic [WIDTH-1:0] mem [CAP];
    assign stk_rd = mem[stk_ra];
    always @(posedge clk) if (stk_we) mem[stk_wa] <= stk_wd;

    typedef struct packed {
        logic [DEPTH:0]   sp;
        logic             skip;
        logic             ovf;
        logic             unf;
        logic             ready;
        logic             jv;
        logic [WIDTH-1:0] jpc;
    } stat_t;

    typedef struct packed {
        logic             we;
        logic [DEPTH-1:0] wa;
        logic [WIDTH-1:0] wd;
    } comb_t;

    stat_t            stat_q [$];
    comb_t            comb_q [$];
    logic [WIDTH-1:0] jump_q [$];
    bit               mon_en = 1'b0;
    int               n_checks = 0;
    int               n_fail = 0;

    // Behavioural model: a PC stack, a nesting count and a few flags
    logic [WIDTH-1:0] m_stk [$];
    int               m_nest;
    bit               m_skip, m_err, m_ovf, m_unf, m_jv;
    logic [WIDTH-1:0] m_jpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stat_t cur_stat();
        stat_t s;
        s.sp    = (DEPTH+1)'(m_stk.size());
        s.skip  = m_skip;
        s.ovf   = m_ovf;
        s.unf   = m_unf;
        s.ready = !m_err;
        s.jv    = m_jv;
        s.jpc   = m_jpc;
        return s;
    endfunction

    task automatic model_reset();
        m_stk.delete();
        m_nest = 0;
        m_skip = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_jv = 1'b0;
        m_jpc  = 16'd0;
    endtask

    task automatic model_step(input logic v, input logic [1:0] op,
                              input logic [WIDTH-1:0] pc, input logic cz);
        comb_t c;
        c.we = 1'b0;
        c.wa = DEPTH'(m_stk.size());
        c.wd = pc;
        m_jv = 1'b0;
        if (v && !m_err) begin
            if (m_skip) begin
                if (op == 2'd1) begin
                    if (m_nest == 65535) begin m_ovf = 1'b1; m_err = 1'b1; m_skip = 1'b0; end
                    else m_nest++;
                end else if (op == 2'd2) begin
                    m_nest--;
                    if (m_nest == 0) m_skip = 1'b0;
                end
            end else if (op == 2'd1) begin
                if (cz) begin
                    m_skip = 1'b1; m_nest = 1;
                end else if (m_stk.size() < CAP) begin
                    m_stk.push_back(pc); c.we = 1'b1;
                end else begin
                    m_ovf = 1'b1; m_err = 1'b1;
                end
            end else if (op == 2'd2) begin
                if (m_stk.size() == 0) begin
                    m_unf = 1'b1; m_err = 1'b1;
                end else if (!cz) begin
                    m_jv  = 1'b1;
                    m_jpc = m_stk[$] + 16'd1;
                    jump_q.push_back(m_jpc);
                end else begin
                    void'(m_stk.pop_back());
                end
            end
        end
        comb_q.push_back(c);
        stat_q.push_back(cur_stat());
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [WIDTH-1:0] pc, input logic cz);
        @(posedge clk); #1;
        if (!mon_en) begin
            stat_q.push_back(cur_stat());
            mon_en = 1'b1;
        end
        cmd_valid = v; cmd_op = op; cmd_pc = pc; cell_zero = cz;
        model_step(v, op, pc, cz);
    endtask

    // Reset is raised between clock edges and its effect checked at once
    task automatic apply_reset();
        @(posedge clk); #1;
        mon_en = 1'b0;
        stat_q.delete(); comb_q.delete(); jump_q.delete();
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_skip", 32'(skip), 32'd0);
        chk("rst_sp", 32'(sp), 32'd0);
        chk("rst_jv", 32'(jump_valid), 32'd0);
        chk("rst_jpc", 32'(jump_pc), 32'd0);
        chk("rst_err", {30'd0, err_overflow, err_underflow}, 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk); #1 rst = 1'b0;
        model_reset();
    endtask

    // Monitor: pops expectations whenever the DUT presents a cycle/jump
    always @(negedge clk) begin
        if (mon_en) begin
            chk("comb_avail", 32'(comb_q.size() != 0), 32'd1);
            if (comb_q.size() != 0) begin
                comb_t c;
                c = comb_q.pop_front();
                chk("stk_we", 32'(stk_we), 32'(c.we));
                if (c.we) begin
                    chk("stk_wa", 32'(stk_wa), 32'(c.wa));
                    chk("stk_wd", 32'(stk_wd), 32'(c.wd));
                end
            end
            chk("stat_avail", 32'(stat_q.size() != 0), 32'd1);
            if (stat_q.size() != 0) begin
                stat_t s;
                s = stat_q.pop_front();
                chk("sp", 32'(sp), 32'(s.sp));
                chk("skip", 32'(skip), 32'(s.skip));
                chk("err_overflow", 32'(err_overflow), 32'(s.ovf));
                chk("err_underflow", 32'(err_underflow), 32'(s.unf));
                chk("cmd_ready", 32'(cmd_ready), 32'(s.ready));
                chk("jump_valid", 32'(jump_valid), 32'(s.jv));
                chk("jump_pc_hold", 32'(jump_pc), 32'(s.jpc));
            end
            if (jump_valid) begin
                chk("jump_avail", 32'(jump_q.size() != 0), 32'd1);
                if (jump_q.size() != 0) chk("jump_pc", 32'(jump_pc), 32'(jump_q.pop_front()));
            end
        end
    end

    initial begin
        logic [1:0] op;
        logic       cz;
        logic       v;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("por_sp", 32'(sp), 32'd0);
        chk("por_skip", 32'(skip), 32'd0);
        chk("por_jv", 32'(jump_valid), 32'd0);
        @(negedge clk); #1 rst = 1'b0;

        // Taken loop, branch back, exit
        drive(1'b1, 2'd1, 16'd5, 1'b0);
        drive(1'b1, 2'd2, 16'd9, 1'b0);
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        drive(1'b1, 2'd2, 16'd9, 1'b0);
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        drive(1'b1, 2'd2, 16'd9, 1'b1);
        // Skip nesting
        drive(1'b1, 2'd1, 16'd20, 1'b1);
        drive(1'b1, 2'd1, 16'd21, 1'b0);
        drive(1'b1, 2'd3, 16'd22, 1'b0);
        drive(1'b1, 2'd2, 16'd23, 1'b0);
        drive(1'b1, 2'd2, 16'd24, 1'b1);
        drive(1'b1, 2'd0, 16'd25, 1'b0);
        // Jump target wraps at the top of the PC space
        drive(1'b1, 2'd1, 16'hFFFF, 1'b0);
        drive(1'b1, 2'd2, 16'd3, 1'b0);
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        drive(1'b1, 2'd2, 16'd3, 1'b1);
        // Overflow on the fifth push
        for (int i = 0; i < 5; i++) drive(1'b1, 2'd1, 16'(100 + i), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 2'd2, 16'd7, 1'b0);
        apply_reset();
        // Underflow straight after reset
        drive(1'b1, 2'd2, 16'd1, 1'b0);
        drive(1'b1, 2'd1, 16'd2, 1'b0);
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        apply_reset();
        // Reset while skipping three levels deep, then push from empty
        drive(1'b1, 2'd1, 16'd30, 1'b1);
        drive(1'b1, 2'd1, 16'd31, 1'b0);
        drive(1'b1, 2'd1, 16'd32, 1'b1);
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        apply_reset();
        drive(1'b1, 2'd1, 16'd40, 1'b0);
        drive(1'b0, 2'd0, 16'd0, 1'b0);

        // Randomised traffic, recovering from errors by reset
        for (int i = 0; i < 800; i++) begin
            if (m_err) begin
                apply_reset();
            end else begin
                v  = ($urandom_range(0, 7) != 0) && !m_jv;
                case ($urandom_range(0, 9))
                    0, 1:    op = 2'd0;
                    2, 3, 4: op = 2'd1;
                    5, 6, 7: op = 2'd2;
                    default: op = 2'd3;
                endcase
                if (op == 2'd2 && m_stk.size() == 0 && !m_skip && $urandom_range(0, 7) != 0) op = 2'd1;
                cz = (op == 2'd1) ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
                drive(v, op, 16'($urandom), cz);
            end
        end
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        @(negedge clk); #1;
        chk("jumps_drained", 32'(jump_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
